// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder and the display driver.
// These include segment codes (active-low {g,f,e,d,c,b,a}), special nibbles and FSM states.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIB_MINUS = 4'hA;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // True when exactly one anode is driven low.
    function automatic logic onehot_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) ||
               (an == 4'b1011) || (an == 4'b0111);
    endfunction

endpackage

// File: rtl/seg_to_nibble.sv
// Maps an active-low segment pattern to a digit nibble.
// Recognised patterns are 0-9, minus (4'hA) and blank (4'hF).
module seg_to_nibble
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Pattern lookup; anything unrecognised is flagged invalid.
    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_MINUS: nibble = NIB_MINUS;
            SEG_BLANK: nibble = NIB_BLANK;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers a signed 3-digit value from a multiplexed seven-segment display scan.
// Each digit is debounced and then captured into a slot. A full frame is converted to binary.
// Handshake: VALID is a one-cycle pulse on the cycle BCDOUT/DOUT take a new frame.
// ERR is a one-cycle pulse for a discarded frame. The two never coincide, and there is no back-pressure.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter logic [15:0] SETTLE = 16'd1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  AN,
    input  logic [6:0]  SEG,
    input  logic        DOT,
    output logic [15:0] BCDOUT,
    output logic [9:0]  DOUT,
    output logic        VALID,
    output logic        ERR
);

    logic [3:0]  an_s, an_p;
    logic [6:0]  seg_s, seg_p;
    logic [15:0] cnt;
    logic        stable, onehot, accept;
    logic [1:0]  idx;
    logic [3:0]  slot_bit, nib;
    logic        bad_code, slot_ok, dig_ok, dig_err;
    logic [3:0]  mask, mask_or;
    logic [15:0] slots, slots_nx, frame;
    state_t      state, state_nx;
    logic [1:0]  step;
    logic [9:0]  acc, acc_nx;
    logic [3:0]  cur_digit;
    logic        go, last_step, fin_ok, v_set, e_set, err_hold;
    logic        unused_dot;

    // The decimal point carries no information for this decoder.
    assign unused_dot = DOT;

    seg_to_nibble u_dec (
        .seg     (seg_s),
        .nibble  (nib),
        .invalid (bad_code)
    );

    assign stable   = (an_s == an_p) && (seg_s == seg_p);
    assign onehot   = onehot_low(an_s);
    assign accept   = stable && onehot && (cnt == SETTLE - 16'd1);
    assign slot_bit = 4'b0001 << idx;
    assign slot_ok  = (idx == 2'd3) ? ((nib == NIB_MINUS) || (nib == NIB_BLANK))
                                    : (nib <= 4'd9);
    assign dig_ok   = accept && !bad_code && slot_ok;
    assign dig_err  = accept && !(!bad_code && slot_ok);
    assign mask_or  = dig_ok ? (mask | slot_bit) : mask;
    assign go       = (state == COLLECT) && (mask_or == 4'hF);

    // Slot index from the active anode: AN[0] units up to AN[3] sign.
    always_comb begin
        idx = 2'd0;
        case (an_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Slot contents including this cycle's accepted digit.
    always_comb begin
        slots_nx = slots;
        if (dig_ok)
            slots_nx[{idx, 2'b00} +: 4] = nib;
    end

    // Conversion datapath: hundreds, then tens, then units.
    always_comb begin
        case (step)
            2'd0:    cur_digit = frame[11:8];
            2'd1:    cur_digit = frame[7:4];
            default: cur_digit = frame[3:0];
        endcase
        acc_nx = (acc * 10'd10) + {6'd0, cur_digit};
    end

    assign last_step = (state == CONVERT) && (step == 2'd2);
    assign fin_ok    = (acc_nx <= 10'd511);
    assign v_set     = last_step && fin_ok;
    assign e_set     = last_step && !fin_ok;

    // Input sampling and stability counter; it saturates at SETTLE so each interval is accepted once.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            an_s  <= 4'hF;
            an_p  <= 4'hF;
            seg_s <= 7'h7F;
            seg_p <= 7'h7F;
            cnt   <= 16'd0;
        end else begin
            an_s  <= AN;
            an_p  <= an_s;
            seg_s <= SEG;
            seg_p <= seg_s;
            if (!stable || !onehot)
                cnt <= 16'd0;
            else if (cnt != SETTLE)
                cnt <= cnt + 16'd1;
        end
    end

    // Slot capture and mask. The mask restarts when a frame is handed off or a bad digit arrives.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            slots <= 16'h0000;
            mask  <= 4'h0;
        end else begin
            slots <= slots_nx;
            if (dig_err || go)
                mask <= 4'h0;
            else
                mask <= mask_or;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (mask_or == 4'hF) state_nx = CONVERT;
            CONVERT: if (step == 2'd2)    state_nx = EMIT;
            EMIT:                         state_nx = COLLECT;
            default:                      state_nx = COLLECT;
        endcase
    end

    // Frame snapshot and accumulator. Later digits can refill the slots without touching this frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            frame <= 16'h0000;
            acc   <= 10'd0;
            step  <= 2'd0;
        end else if (go) begin
            frame <= slots_nx;
            acc   <= 10'd0;
            step  <= 2'd0;
        end else if (state == CONVERT) begin
            acc   <= acc_nx;
            step  <= step + 2'd1;
        end
    end

    // Output registers. A digit error is deferred by one cycle so it never lands on a VALID cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            BCDOUT   <= 16'hF000;
            DOUT     <= 10'd0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
            err_hold <= 1'b0;
        end else begin
            VALID <= v_set;
            if (v_set) begin
                BCDOUT   <= frame;
                DOUT     <= {frame[15:12] == NIB_MINUS, acc_nx[8:0]};
                ERR      <= 1'b0;
                err_hold <= err_hold | dig_err;
            end else begin
                ERR      <= dig_err | err_hold | e_set;
                err_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder using SETTLE = 8.
module tb_ssd_scan_decoder;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SX = 7'b1010101;

    localparam logic [3:0] A_SIGN = 4'b0111;
    localparam logic [3:0] A_HUN  = 4'b1011;
    localparam logic [3:0] A_TEN  = 4'b1101;
    localparam logic [3:0] A_UNI  = 4'b1110;
    localparam logic [3:0] A_OFF  = 4'b1111;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DOT;
    logic [15:0] BCDOUT;
    logic [9:0]  DOUT;
    logic        VALID;
    logic        ERR;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int v0, e0;

    ssd_scan_decoder #(.SETTLE(16'd8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .AN     (AN),
        .SEG    (SEG),
        .DOT    (DOT),
        .BCDOUT (BCDOUT),
        .DOUT   (DOUT),
        .VALID  (VALID),
        .ERR    (ERR)
    );

    // Clock generation
    always #5 CLK = ~CLK;

    // Pulse monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (VALID) valid_cnt++;
        if (ERR) err_cnt++;
        if (VALID && ERR) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        AN  = an;
        SEG = seg;
        repeat (n) tick();
    endtask

    task automatic blank();
        drive(A_OFF, SB, 6);
    endtask

    task automatic frame4(input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0);
        drive(A_SIGN, s3, 20);
        drive(A_HUN,  s2, 20);
        drive(A_TEN,  s1, 20);
        drive(A_UNI,  s0, 20);
        blank();
    endtask

    task automatic mark();
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        RST = 1'b0;
        AN  = A_OFF;
        SEG = SB;
        DOT = 1'b0;
        repeat (3) tick();
        check("rst_bcd",   BCDOUT, 32'hF000);
        check("rst_dout",  DOUT,   32'h0);
        check("rst_valid", VALID,  32'h0);
        check("rst_err",   ERR,    32'h0);
        RST = 1'b1;
        tick();

        // "-123", measuring latency on the final digit
        mark();
        drive(A_SIGN, SM, 20);
        drive(A_HUN,  S1, 20);
        drive(A_TEN,  S2, 20);
        AN = A_UNI; SEG = S3;
        repeat (12) tick();
        check("lat_before", VALID, 32'h0);
        tick();
        check("lat_valid", VALID,  32'h1);
        check("m123_bcd",  BCDOUT, 32'hA123);
        check("m123_dout", DOUT,   32'h27B);
        tick();
        check("lat_after", VALID, 32'h0);
        repeat (7) tick();
        blank();
        check("m123_vcnt", valid_cnt - v0, 32'd1);
        check("m123_ecnt", err_cnt - e0,   32'd0);

        // " 045" scanned in order sign, units, hundreds, tens
        mark();
        drive(A_SIGN, SB, 20);
        drive(A_UNI,  S5, 20);
        drive(A_HUN,  S0, 20);
        drive(A_TEN,  S4, 20);
        blank();
        check("p045o_bcd",  BCDOUT, 32'hF045);
        check("p045o_dout", DOUT,   32'h02D);
        check("p045o_vcnt", valid_cnt - v0, 32'd1);

        // " 600" overflows the 9-bit magnitude
        mark();
        frame4(SB, S6, S0, S0);
        check("p600_ecnt", err_cnt - e0,   32'd1);
        check("p600_vcnt", valid_cnt - v0, 32'd0);
        check("p600_bcd",  BCDOUT, 32'hF045);
        check("p600_dout", DOUT,   32'h02D);

        // " 511" is the largest magnitude that is emitted
        mark();
        frame4(SB, S5, S1, S1);
        check("p511_bcd",  BCDOUT, 32'hF511);
        check("p511_dout", DOUT,   32'h1FF);
        check("p511_vcnt", valid_cnt - v0, 32'd1);

        // " 512" is one past the limit
        mark();
        frame4(SB, S5, S1, S2);
        check("p512_ecnt", err_cnt - e0,   32'd1);
        check("p512_vcnt", valid_cnt - v0, 32'd0);
        check("p512_bcd",  BCDOUT, 32'hF511);
        check("p512_dout", DOUT,   32'h1FF);

        // An invalid tens pattern discards the partial frame
        mark();
        drive(A_SIGN, SM, 20);
        drive(A_HUN,  S0, 20);
        drive(A_TEN,  SX, 20);
        check("badseg_ecnt", err_cnt - e0, 32'd1);
        mark();
        drive(A_TEN, S0, 20);
        drive(A_UNI, S7, 20);
        blank();
        check("badseg_mask_clear", valid_cnt - v0, 32'd0);
        drive(A_SIGN, SM, 20);
        drive(A_HUN,  S0, 20);
        blank();
        check("m007_vcnt", valid_cnt - v0, 32'd1);
        check("m007_bcd",  BCDOUT, 32'hA007);
        check("m007_dout", DOUT,   32'h207);

        // " 045" in natural order
        mark();
        frame4(SB, S0, S4, S5);
        check("p045_bcd",  BCDOUT, 32'hF045);
        check("p045_dout", DOUT,   32'h02D);
        check("p045_vcnt", valid_cnt - v0, 32'd1);

        // Glitches: toggling units segments, then two anodes low with toggling segments
        mark();
        for (int i = 0; i < 4; i++)
            drive(A_UNI, (i % 2 == 0) ? S0 : S1, 5);
        for (int i = 0; i < 4; i++)
            drive(4'b1100, (i % 2 == 0) ? S8 : S3, 5);
        blank();
        drive(A_SIGN, SB, 20);
        drive(A_HUN,  S0, 20);
        drive(A_TEN,  S8, 20);
        blank();
        check("glitch_vcnt", valid_cnt - v0, 32'd0);
        check("glitch_ecnt", err_cnt - e0,   32'd0);
        drive(A_UNI, S9, 20);
        blank();
        check("p089_vcnt", valid_cnt - v0, 32'd1);
        check("p089_bcd",  BCDOUT, 32'hF089);
        check("p089_dout", DOUT,   32'h059);

        // Reset while the frame is converting
        mark();
        drive(A_SIGN, SM, 20);
        drive(A_HUN,  S1, 20);
        drive(A_TEN,  S2, 20);
        drive(A_UNI,  S3, 11);
        RST = 1'b0;
        AN  = A_OFF;
        SEG = SB;
        tick();
        RST = 1'b1;
        repeat (20) tick();
        check("rstcv_vcnt", valid_cnt - v0, 32'd0);
        check("rstcv_ecnt", err_cnt - e0,   32'd0);
        check("rstcv_bcd",  BCDOUT, 32'hF000);
        check("rstcv_dout", DOUT,   32'h0);

        check("valid_err_overlap", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
